// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock first-word-fall-through FIFO with
// full / almost-full / empty / almost-empty status flags.
module fifo_sync_core #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_nxt;
  logic [PW-1:0]    rptr_nxt;
  logic [PW-1:0]    cnt_nxt;
  logic             we;
  logic             re;

  // Accept qualification and next-state pointers; flags are derived from these.
  always_comb begin
    we       = winc & ~wfull;
    re       = rinc & ~rempty;
    wptr_nxt = wptr + PW'(we);
    rptr_nxt = rptr + PW'(re);
    cnt_nxt  = wptr_nxt - rptr_nxt;
  end

  // Pointer and status flag registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      rempty  <= 1'b1;
      arempty <= 1'b1;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      wfull   <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                 (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
      awfull  <= (cnt_nxt >= PW'(DEPTH - 1));
      arempty <= (cnt_nxt <= PW'(1));
      rempty  <= (cnt_nxt == '0);
    end
  end

  // Storage array; cleared on reset so the head reads zero when empty.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  // Head of queue falls through to the read port.
  assign rdata = mem[rptr[ASIZE-1:0]];

endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: directed self-checking bench for fifo_sync_core.
module tb_fifo_sync_core;

  logic        wclk;
  logic        wrst_n;
  logic        winc;
  logic [31:0] wdata;
  logic        wfull;
  logic        awfull;
  logic        rinc;
  logic [31:0] rdata;
  logic        rempty;
  logic        arempty;

  int total;
  int bad;
  logic [31:0] q[$];
  logic [31:0] exp_word;

  fifo_sync_core #(.DSIZE(32), .ASIZE(4)) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .winc    (winc),
    .wdata   (wdata),
    .wfull   (wfull),
    .awfull  (awfull),
    .rinc    (rinc),
    .rdata   (rdata),
    .rempty  (rempty),
    .arempty (arempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given request inputs; returns 1ns after the edge.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge wclk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic flags(input string tag, input logic e, input logic ae,
                       input logic af, input logic f);
    chk({tag, "_rempty"}, 32'(rempty), 32'(e));
    chk({tag, "_arempty"}, 32'(arempty), 32'(ae));
    chk({tag, "_awfull"}, 32'(awfull), 32'(af));
    chk({tag, "_wfull"}, 32'(wfull), 32'(f));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    wrst_n = 1'bx;
    #10 wrst_n = 1'b0;
    #2;
    flags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    #8 wrst_n = 1'b1;
    @(posedge wclk);
    #1;

    // Single word in and out.
    cyc(1'b1, 32'h0000_0001, 1'b0);
    flags("one", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("one_rdata", rdata, 32'h0000_0001);
    cyc(1'b0, 32'h0, 1'b1);
    flags("one_pop", 1'b1, 1'b1, 1'b0, 1'b0);

    // Fill to full, then overflow attempt.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), 1'b0);
      if (i == 13) flags("fill14", 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 14) flags("fill15", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    flags("full", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("full_rdata", rdata, 32'h100);
    cyc(1'b1, 32'hDEAD, 1'b0);
    flags("ovf", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_rdata", rdata, 32'h100);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rdata, 32'h100 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1);
      chk("drain_arempty", 32'(arempty), 32'((15 - i) <= 1));
      chk("drain_rempty", 32'(rempty), 32'(i == 15));
    end

    // Full with simultaneous write and read: only the read is taken.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    flags("full2", 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'hBEEF, 1'b1);
    flags("full_rw", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_rw_rdata", rdata, 32'h201);
    for (int i = 1; i < 16; i++) begin
      chk("drain2_data", rdata, 32'h200 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1);
    end
    flags("drain2_end", 1'b1, 1'b1, 1'b0, 1'b0);

    // Empty with simultaneous write and read: only the write is taken.
    cyc(1'b1, 32'h55, 1'b1);
    flags("empty_rw", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_rw_rdata", rdata, 32'h55);
    cyc(1'b0, 32'h0, 1'b1);
    flags("pop55", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    flags("udf", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h66, 1'b0);
    flags("after_udf", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("after_udf_rdata", rdata, 32'h66);
    cyc(1'b0, 32'h0, 1'b1);

    // Steady stream at count 8 across several pointer wraps.
    q.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h300 + 32'(i), 1'b0);
      q.push_back(32'h300 + 32'(i));
    end
    for (int i = 0; i < 40; i++) begin
      exp_word = q.pop_front();
      chk("stream_data", rdata, exp_word);
      cyc(1'b1, 32'h400 + 32'(i), 1'b1);
      q.push_back(32'h400 + 32'(i));
    end
    flags("stream", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_word = q.pop_front();
      chk("stream_drain", rdata, exp_word);
      cyc(1'b0, 32'h0, 1'b1);
      chk("stream_drain_arempty", 32'(arempty), 32'((7 - i) <= 1));
      chk("stream_drain_rempty", 32'(rempty), 32'(i == 7));
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0);
    cyc(1'b1, 32'h600, 1'b1);
    chk("pre_rst_rdata", rdata, 32'h501);
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 32'h601;
    #3 wrst_n = 1'b0;
    #1;
    flags("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_rdata", rdata, 32'h0);
    winc = 1'b0;
    rinc = 1'b0;
    #2 wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    flags("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 1'b0);
    flags("post_rst_wr", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_rdata", rdata, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
